// File: rtl/ram_master_pkg.sv
// Shared definitions for the RAM strobe initiator: FSM state encoding,
// default bus geometry and the address range helper.
package ram_master_pkg;

  localparam int RM_AW    = 6;
  localparam int RM_DW    = 8;
  localparam int RM_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_SAMPLE,
    ST_RELEASE
  } rm_state_t;

  function automatic logic addr_in_range(input logic [31:0] a, input int depth);
    return (a < 32'(depth));
  endfunction

endpackage

// File: rtl/ram_master.sv
// Initiator for the asynchronous RAM strobe interface: one request at a time,
// sequenced as SETUP/STROBE/(SAMPLE)/RELEASE. Optional macro RAM_MASTER_RANGE_EN
// short-circuits out-of-range requests with err=1 and no RAM strobes.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int AW    = RM_AW,
  parameter int DW    = RM_DW,
  parameter int DEPTH = RM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_read,
  output logic          ram_write,
  output logic          ram_ena,
  input  logic [DW-1:0] ram_data
);

  rm_state_t     state_reg;
  logic          we_reg;
  logic          ready_reg;
  logic          done_reg;
  logic [DW-1:0] rdata_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_din_reg;
  logic          ram_read_reg;
  logic          ram_write_reg;
  logic          ram_ena_reg;

`ifdef RAM_MASTER_RANGE_EN
  logic err_reg;
  assign err = err_reg;
`else
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);
  assign err          = 1'b0;
`endif

  // Every output is driven straight from a flop so the RAM never sees a glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      ready_reg     <= 1'b1;
      done_reg      <= 1'b0;
      rdata_reg     <= '0;
      ram_addr_reg  <= '0;
      ram_din_reg   <= '0;
      ram_read_reg  <= 1'b0;
      ram_write_reg <= 1'b0;
      ram_ena_reg   <= 1'b1;
`ifdef RAM_MASTER_RANGE_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            ready_reg <= 1'b0;
            we_reg    <= we;
`ifdef RAM_MASTER_RANGE_EN
            if (!addr_in_range(32'(addr), DEPTH)) begin
              state_reg <= ST_RELEASE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else
`endif
            begin
              state_reg    <= ST_SETUP;
              ram_addr_reg <= addr;
              if (we) begin
                // Write strobe must already be high when ena falls next cycle.
                ram_din_reg   <= wdata;
                ram_write_reg <= 1'b1;
                ram_ena_reg   <= 1'b1;
              end else begin
                ram_ena_reg  <= 1'b0;
                ram_read_reg <= 1'b0;
              end
            end
          end
        end

        ST_SETUP: begin
          state_reg <= ST_STROBE;
          if (we_reg) ram_ena_reg  <= 1'b0;
          else        ram_read_reg <= 1'b1;
        end

        ST_STROBE: begin
          if (we_reg) begin
            state_reg     <= ST_RELEASE;
            ram_ena_reg   <= 1'b1;
            ram_write_reg <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            state_reg <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          // The RAM has been driving the bus for a full cycle by now.
          rdata_reg    <= ram_data;
          state_reg    <= ST_RELEASE;
          ram_read_reg <= 1'b0;
          ram_ena_reg  <= 1'b1;
          done_reg     <= 1'b1;
        end

        ST_RELEASE: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
`ifdef RAM_MASTER_RANGE_EN
          err_reg   <= 1'b0;
`endif
        end

        default: begin
          state_reg     <= ST_IDLE;
          ready_reg     <= 1'b1;
          ram_read_reg  <= 1'b0;
          ram_write_reg <= 1'b0;
          ram_ena_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_reg;
  assign done      = done_reg;
  assign rdata     = rdata_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_din   = ram_din_reg;
  assign ram_read  = ram_read_reg;
  assign ram_write = ram_write_reg;
  assign ram_ena   = ram_ena_reg;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural 4-word strobe RAM.
// Define RAM_MASTER_RANGE_EN to also exercise the out-of-range path.
module tb_ram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       err;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_read;
  logic       ram_write;
  logic       ram_ena;
  logic [7:0] ram_data;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int ena_falls = 0;
  logic [7:0] mem [0:3];

  always #5 clk = ~clk;

  ram_master #(.AW(6), .DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .err(err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_read(ram_read),
    .ram_write(ram_write), .ram_ena(ram_ena), .ram_data(ram_data)
  );

  // RAM model: write commits on falling ena, data driven while enabled and reading.
  initial begin
    mem[0] = 8'hF0; mem[1] = 8'hF1; mem[2] = 8'hF2; mem[3] = 8'hF3;
    forever begin
      @(negedge ram_ena);
      if (ram_write === 1'b1 && ram_addr < 6'd4) mem[ram_addr[1:0]] = ram_din;
    end
  end

  always_comb begin
    ram_data = 'z;
    if (ram_ena === 1'b0 && ram_read === 1'b1 && ram_addr < 6'd4) ram_data = mem[ram_addr[1:0]];
  end

  always @(negedge ram_ena) ena_falls++;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (ram_read === 1'b1 && ram_write === 1'b1) begin
      errors++;
      $display("FAIL strobe_overlap: read=%b write=%b required not both 1", ram_read, ram_write);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h required 00", rdata); end
    checks++; if (ram_addr !== 6'h00 || ram_din !== 8'h00) begin errors++; $display("FAIL rst_bus: addr %h din %h required 00 00", ram_addr, ram_din); end
    checks++; if (ram_read !== 1'b0 || ram_write !== 1'b0 || ram_ena !== 1'b1) begin errors++; $display("FAIL rst_strobes: read %b write %b ena %b required 0 0 1", ram_read, ram_write, ram_ena); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: ready=%b ena=%b", ready, ram_ena);
  endtask

  task automatic test_write(input logic [5:0] a, input logic [7:0] d);
    int falls0;
    falls0 = ena_falls;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_ready_pre: got %b required 1", ready); end
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); req = 1'b0;  // cycle 1: SETUP
    checks++; if (ready !== 1'b0 || ram_write !== 1'b1 || ram_ena !== 1'b1) begin errors++; $display("FAIL wr_setup: ready %b write %b ena %b required 0 1 1", ready, ram_write, ram_ena); end
    checks++; if (ram_addr !== a || ram_din !== d) begin errors++; $display("FAIL wr_setup_bus: addr %h din %h required %h %h", ram_addr, ram_din, a, d); end
    @(negedge clk);              // cycle 2: STROBE
    checks++; if (ram_ena !== 1'b0 || ram_write !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wr_strobe: ena %b write %b done %b required 0 1 0", ram_ena, ram_write, done); end
    @(negedge clk);              // cycle 3: RELEASE
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_done: done %b err %b required 1 0", done, err); end
    checks++; if (ram_ena !== 1'b1 || ram_write !== 1'b0 || ram_addr !== a || ram_din !== d) begin errors++; $display("FAIL wr_release: ena %b write %b addr %h din %h required 1 0 %h %h", ram_ena, ram_write, ram_addr, ram_din, a, d); end
    checks++; if (mem[a[1:0]] !== d || ena_falls != falls0 + 1) begin errors++; $display("FAIL wr_commit: mem %h falls %0d required %h 1", mem[a[1:0]], ena_falls - falls0, d); end
    @(negedge clk);              // cycle 4: IDLE
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wr_idle: ready %b done %b required 1 0", ready, done); end
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic test_read(input logic [5:0] a, input logic [7:0] exp);
    req = 1'b1; we = 1'b0; addr = a; wdata = 8'h5A;
    @(negedge clk); req = 1'b0;  // cycle 1: SETUP
    checks++; if (ready !== 1'b0 || ram_ena !== 1'b0 || ram_read !== 1'b0 || ram_addr !== a) begin errors++; $display("FAIL rd_setup: ready %b ena %b read %b addr %h required 0 0 0 %h", ready, ram_ena, ram_read, ram_addr, a); end
    @(negedge clk);              // cycle 2: STROBE
    checks++; if (ram_read !== 1'b1 || ram_ena !== 1'b0 || ram_write !== 1'b0) begin errors++; $display("FAIL rd_strobe: read %b ena %b write %b required 1 0 0", ram_read, ram_ena, ram_write); end
    @(negedge clk);              // cycle 3: SAMPLE
    checks++; if (done !== 1'b0 || ram_read !== 1'b1 || ram_ena !== 1'b0) begin errors++; $display("FAIL rd_sample: done %b read %b ena %b required 0 1 0", done, ram_read, ram_ena); end
    @(negedge clk);              // cycle 4: RELEASE
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== exp) begin errors++; $display("FAIL rd_done: done %b err %b rdata %h required 1 0 %h", done, err, rdata, exp); end
    checks++; if (ram_read !== 1'b0 || ram_ena !== 1'b1 || ram_addr !== a) begin errors++; $display("FAIL rd_release: read %b ena %b addr %h required 0 1 %h", ram_read, ram_ena, ram_addr, a); end
    @(negedge clk);              // cycle 5: IDLE
    checks++; if (ready !== 1'b1 || done !== 1'b0 || rdata !== exp) begin errors++; $display("FAIL rd_idle: ready %b done %b rdata %h required 1 0 %h", ready, done, rdata, exp); end
    $display("read addr=%h data=%h expected=%h", a, rdata, exp);
  endtask

  task automatic test_busy_ignore();
    int dones0, falls0;
    dones0 = done_count; falls0 = ena_falls;
    req = 1'b1; we = 1'b1; addr = 6'd0; wdata = 8'h33;
    @(negedge clk); req = 1'b0;                          // SETUP
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 6'd1;  // STROBE: must be ignored
    @(negedge clk); req = 1'b0;                          // RELEASE
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b required 1", done); end
    @(negedge clk);                                      // cycle 4
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_ready: got %b required 1", ready); end
    repeat (4) @(negedge clk);
    checks++; if (done_count != dones0 + 1) begin errors++; $display("FAIL busy_done_count: got %0d required 1", done_count - dones0); end
    checks++; if (ena_falls != falls0 + 1 || ram_ena !== 1'b1 || ram_read !== 1'b0) begin errors++; $display("FAIL busy_accesses: falls %0d ena %b read %b required 1 1 0", ena_falls - falls0, ram_ena, ram_read); end
    checks++; if (mem[0] !== 8'h33) begin errors++; $display("FAIL busy_mem: got %h required 33", mem[0]); end
    $display("busy_ignore: dones=%0d accesses=%0d", done_count - dones0, ena_falls - falls0);
  endtask

  task automatic test_reset_mid_read();
    int dones0;
    dones0 = done_count;
    req = 1'b1; we = 1'b0; addr = 6'd3;
    @(negedge clk); req = 1'b0;   // SETUP
    @(negedge clk);               // STROBE
    @(negedge clk); rst_n = 1'b0; // SAMPLE
    @(negedge clk);
    checks++; if (ram_ena !== 1'b1 || ram_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_strobes: ena %b read %b done %b required 1 0 0", ram_ena, ram_read, done); end
    checks++; if (ready !== 1'b1 || rdata !== 8'h00 || ram_addr !== 6'h00) begin errors++; $display("FAIL midrst_state: ready %b rdata %h addr %h required 1 00 00", ready, rdata, ram_addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_count != dones0 || ready !== 1'b1) begin errors++; $display("FAIL midrst_nodone: dones %0d ready %b required 0 1", done_count - dones0, ready); end
    $display("reset_mid_read: ready=%b ena=%b", ready, ram_ena);
  endtask

`ifdef RAM_MASTER_RANGE_EN
  task automatic test_range();
    int falls0;
    falls0 = ena_falls;
    req = 1'b1; we = 1'b0; addr = 6'd5;
    @(negedge clk); req = 1'b0;   // cycle 1: RELEASE directly
    checks++; if (done !== 1'b1 || err !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL range_done: done %b err %b ready %b required 1 1 0", done, err, ready); end
    checks++; if (ram_ena !== 1'b1 || ram_read !== 1'b0 || rdata !== 8'hA5) begin errors++; $display("FAIL range_bus: ena %b read %b rdata %h required 1 0 a5", ram_ena, ram_read, rdata); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || ena_falls != falls0) begin errors++; $display("FAIL range_idle: ready %b done %b err %b falls %0d required 1 0 0 0", ready, done, err, ena_falls - falls0); end
    $display("range: addr=05 err flagged, rdata=%h", rdata);
  endtask
`endif

  initial begin
    test_reset();
    test_read(6'd1, 8'hF1);
    test_write(6'd2, 8'hA5);
    test_read(6'd2, 8'hA5);
    test_write(6'd3, 8'h5C);
    test_read(6'd3, 8'h5C);
    test_busy_ignore();
    test_read(6'd0, 8'h33);
    test_reset_mid_read();
    test_read(6'd2, 8'hA5);
`ifdef RAM_MASTER_RANGE_EN
    test_range();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_master.md
# ram_master

Initiator side of the simple CPU's asynchronous RAM strobe interface. It accepts single-beat read/write requests from the core over a registered request/done handshake. It converts each request into a glitch-free, multi-cycle sequence on the RAM's `addr/din/read/write/ena` lines, which include an active-low `ena` and level/edge-triggered strobes. For reads it captures the RAM's tri-stated `data` bus into a register. It sits between the CPU control unit and `ram`.

## Interface
- `AW`, default 6: address width, matches the RAM `addr`.
- `DW`, default 8: data width, matches the RAM `data`/`din`.
- `DEPTH`, default 4: number of implemented RAM locations. Used only by the range check.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  1  core request. Sampled only when `ready`=1.
- `we`  in  1  1=write, 0=read. Qualified by `req`.
- `addr`  in  AW  request address.
- `wdata`  in  DW  write data.
- `ready`  out  1  block idle and able to accept a request.
- `done`  out  1  one-cycle pulse marking request completion.
- `rdata`  out  DW  read result. Valid when `done`=1 for a read; holds until the next read completes.
- `err`  out  1  out-of-range flag. Valid with `done`.
- `ram_addr`  out  AW  address to RAM.
- `ram_din`  out  DW  write data to RAM.
- `ram_read`  out  1  RAM read strobe, active-high.
- `ram_write`  out  1  RAM write strobe, active-high.
- `ram_ena`  out  1  RAM enable, active-low (1 = RAM disabled, data bus Z).
- `ram_data`  in  DW  RAM data bus. Z when the RAM is not reading.

## Operation
- FSM states: IDLE, SETUP, STROBE, SAMPLE, RELEASE. All outputs are registered.
- IDLE: `ready`=1, `ram_ena`=1, strobes 0. On `req`=1, latch `we`/`addr`/`wdata` and go to SETUP.
- Write sequence. The RAM acts only on `read`/`ena` edges, so `write` must be stable before the `ena` falls.
  - SETUP: `ram_addr`/`ram_din` driven, `ram_write`=1, `ram_ena`=1.
  - STROBE: `ram_ena`=0. The falling edge commits the write.
  - RELEASE: `ram_ena`=1, `ram_write`=0, `done`=1.
- Read sequence:
  - SETUP: `ram_addr` driven, `ram_ena`=0, `ram_read`=0.
  - STROBE: `ram_read`=1. The rising edge makes the RAM drive `data`.
  - SAMPLE: `rdata` <= `ram_data` at the end of the cycle.
  - RELEASE: `ram_read`=0, `ram_ena`=1, `done`=1.
- `ram_read` and `ram_write` are never both 1. `we`=1 always selects write.
- `ram_addr` and `ram_din` stay constant from SETUP through RELEASE. Between requests they hold their last value.
- RELEASE always returns to IDLE. `req` arriving during a busy state is ignored; it is not queued.
- `err`=0 on every completion unless the feature in Configuration is enabled.

## Timing
- Edge E0 accepts the request.
- Read: SETUP in cycle 1, STROBE in cycle 2, SAMPLE in cycle 3. RELEASE in cycle 4, with `done`=1 and `rdata` valid. IDLE with `ready`=1 in cycle 5. Latency is 4 cycles from acceptance to `done`.
- Write: SETUP in cycle 1, STROBE in cycle 2, RELEASE in cycle 3 with `done`=1, IDLE in cycle 4. Latency is 3 cycles.
- `ready` is 0 from cycle 1 through RELEASE. Back-to-back throughput is one read per 5 cycles or one write per 4 cycles.
- Reset values: `ready`=1, `done`=0, `err`=0, `rdata`=0, `ram_addr`=0, `ram_din`=0, `ram_read`=0, `ram_write`=0, `ram_ena`=1.
- Reset mid-operation: at the first edge with `rst_n`=0, every output takes its reset value and the state goes to IDLE. No `done` is issued, and the partial RAM access is abandoned.

## Configuration
- Macro: `RAM_MASTER_RANGE_EN`.
- Defined: when `addr` >= `DEPTH` at acceptance, the FSM goes IDLE -> RELEASE directly. No RAM strobes are issued and `ram_ena` stays 1. `done`=1 and `err`=1 in cycle 1, and `rdata` is unchanged. In-range requests behave normally with `err`=0.
- Undefined: all addresses are forwarded and `err` is tied to 0. A read of an unmapped address captures whatever is on `ram_data`, which is Z/X in simulation.

## Structure
- Package `ram_master_pkg`: the FSM state enum and the default `AW`/`DW`/`DEPTH` constants, shared with the CPU control unit.
- Single module with no sub-module. The request latch, FSM and output registers all live in one block.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles -> all outputs at their reset values, `ready`=1.
- Write then read back: write `addr`=2, `wdata`=0xA5, then read `addr`=2.
  - Write: `done` in cycle 3, `ram_write`=1 throughout the cycle where `ram_ena` falls.
  - Read: `done` in cycle 4, `rdata`=0xA5.
- Read initial contents: read `addr`=1 after reset -> `rdata`=0xF1. A RAM model checker confirms `ram_read` and `ram_write` are never both 1.
- Busy ignore: pulse `req` during STROBE of a write -> no second access, one `done` only, `ready`=1 at cycle 4.
- Reset mid-read: drop `rst_n` in SAMPLE -> next cycle `ram_ena`=1, `ram_read`=0, `done`=0, state IDLE.
- With `RAM_MASTER_RANGE_EN`: read `addr`=5 -> `done`=1 and `err`=1 in cycle 1, `ram_ena` never 0, `rdata` unchanged.
